// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - four-way shared IO arbiter with hold timeout, release gap and hog lockout
// Round-robin or fixed-priority grant, registered one-hot and encoded outputs.
module io_arbiter #(
   parameter int RR_EN   = 1,
   parameter int GAP     = 1,
   parameter int TMO_W   = 8,
   parameter int TIMEOUT = 200
)(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] i_req,
   input  logic [3:0] i_rel,
   output logic [3:0] o_gnt,
   output logic [1:0] o_gnt_id,
   output logic       o_gnt_valid,
   output logic       o_timeout
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1, S_GAP = 2'd2} state_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [1:0]       GAP_LAST = 2'(GAP - 1);
   localparam bit               TMO_ON   = (TIMEOUT != 0);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_gnt;
   logic [1:0]       r_gnt_id;
   logic [1:0]       r_last;
   logic [3:0]       r_mask;
   logic [TMO_W-1:0] r_timer;
   logic [1:0]       r_gap_cnt;
   logic             r_timeout;

   logic [3:0]       w_elig;
   logic             w_found;
   logic [1:0]       w_win_id;
   logic             w_rel_hit;
   logic             w_req_drop;
   logic             w_tmo_hit;
   logic             w_own_end;
   logic             w_tmo_only;

   assign w_elig = i_req & ~r_mask;

   // Search order starts just after the last winner, or at requester 3 in fixed mode.
   always_comb begin
      logic [1:0] v_idx;
      w_found  = 1'b0;
      w_win_id = 2'd0;
      v_idx    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (RR_EN != 0) v_idx = r_last + 2'd1 + 2'(k);
         else            v_idx = 2'(3 - k);
         if (!w_found && w_elig[v_idx]) begin
            w_found  = 1'b1;
            w_win_id = v_idx;
         end
      end
   end

   assign w_rel_hit  = i_rel[r_gnt_id];
   assign w_req_drop = ~i_req[r_gnt_id];
   assign w_tmo_hit  = TMO_ON && (r_timer == TMO_LAST);
   assign w_own_end  = (r_state == S_OWN) && (w_rel_hit || w_req_drop || w_tmo_hit);
   assign w_tmo_only = w_own_end && w_tmo_hit && !w_rel_hit && !w_req_drop;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_found) w_next = S_OWN;
         S_OWN:  if (w_own_end) w_next = (GAP > 0) ? S_GAP : S_IDLE;
         S_GAP:  if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_gnt     <= 4'b0;
         r_gnt_id  <= 2'd0;
         r_last    <= 2'd3;
         r_mask    <= 4'b0;
         r_timer   <= '0;
         r_gap_cnt <= 2'd0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_tmo_only;
         // A requester only regains eligibility after one cycle with its request low.
         r_mask    <= (r_mask & i_req) | (w_tmo_only ? r_gnt : 4'b0);
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_gnt    <= 4'b0001 << w_win_id;
                  r_gnt_id <= w_win_id;
                  r_last   <= w_win_id;
                  r_timer  <= '0;
               end
            end
            S_OWN: begin
               if (w_own_end) begin
                  r_gnt     <= 4'b0;
                  r_gap_cnt <= 2'd0;
               end else if (r_timer != '1) begin
                  r_timer <= r_timer + TMO_W'(1);
               end
            end
            S_GAP:   r_gap_cnt <= r_gap_cnt + 2'd1;
            default: r_gap_cnt <= 2'd0;
         endcase
      end
   end

   assign o_gnt       = r_gnt;
   assign o_gnt_id    = r_gnt_id;
   assign o_gnt_valid = |r_gnt;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - io_arbiter bench: directed scenarios plus random traffic vs behavioural model
// Two instances (round-robin with timeout, fixed priority without) share one stimulus.
module tb_io_arbiter;

   logic       CLK;
   logic       RST_N;
   logic [3:0] req;
   logic [3:0] rel;

   logic [3:0] d_gnt [2];
   logic [1:0] d_id  [2];
   logic       d_val [2];
   logic       d_to  [2];

   int vectors;
   int miscompares;

   io_arbiter #(.RR_EN(1), .GAP(1), .TMO_W(8), .TIMEOUT(8)) u0 (
      .CLK(CLK), .RST_N(RST_N), .i_req(req), .i_rel(rel),
      .o_gnt(d_gnt[0]), .o_gnt_id(d_id[0]), .o_gnt_valid(d_val[0]), .o_timeout(d_to[0]));

   io_arbiter #(.RR_EN(0), .GAP(0), .TMO_W(4), .TIMEOUT(0)) u1 (
      .CLK(CLK), .RST_N(RST_N), .i_req(req), .i_rel(rel),
      .o_gnt(d_gnt[1]), .o_gnt_id(d_id[1]), .o_gnt_valid(d_val[1]), .o_timeout(d_to[1]));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural model: owner index (-1 = none), cycles already held, gap cycles left.
   int         p_rr  [2] = '{1, 0};
   int         p_gap [2] = '{1, 0};
   int         p_tmo [2] = '{8, 0};
   int         m_owner [2];
   int         m_held  [2];
   int         m_gap   [2];
   int         m_last  [2];
   int         m_id    [2];
   bit         m_to    [2];
   logic [3:0] m_mask  [2];

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1; m_held[k] = 0; m_gap[k] = 0;
         m_last[k] = 3; m_id[k] = 0; m_to[k] = 0; m_mask[k] = 4'b0;
      end
   endtask

   task automatic m_step(input int k, input logic [3:0] rq, input logic [3:0] rl);
      logic [3:0] nm;
      int o, c;
      bit a, b, t, found;
      nm = m_mask[k] & rq;
      m_to[k] = 0;
      if (m_owner[k] >= 0) begin
         o = m_owner[k];
         a = rl[o];
         b = !rq[o];
         t = (p_tmo[k] != 0) && (m_held[k] == p_tmo[k] - 1);
         if (a || b || t) begin
            if (t && !a && !b) begin
               m_to[k] = 1;
               nm[o] = 1'b1;
            end
            m_owner[k] = -1;
            m_gap[k] = p_gap[k];
         end else begin
            m_held[k]++;
         end
      end else if (m_gap[k] > 0) begin
         m_gap[k]--;
      end else begin
         found = 0;
         for (int j = 1; j <= 4; j++) begin
            c = (p_rr[k] != 0) ? (m_last[k] + j) % 4 : 4 - j;
            if (!found && rq[c] && !m_mask[k][c]) begin
               found = 1;
               m_owner[k] = c; m_held[k] = 0; m_last[k] = c; m_id[k] = c;
            end
         end
      end
      m_mask[k] = nm;
   endtask

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) m_reset();
      else for (int k = 0; k < 2; k++) m_step(k, req, rel);
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         int eg;
         eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
         chk($sformatf("u%0d gnt", k), int'(d_gnt[k]), eg);
         chk($sformatf("u%0d gnt_valid", k), int'(d_val[k]), int'(eg != 0));
         chk($sformatf("u%0d timeout", k), int'(d_to[k]), int'(m_to[k]));
         if (eg != 0) chk($sformatf("u%0d gnt_id", k), int'(d_id[k]), m_id[k]);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      #2;
      RST_N = 1'b0;
      req = 4'b0;
      rel = 4'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   initial begin
      int hi, low;
      vectors = 0;
      miscompares = 0;
      m_reset();
      RST_N = 1'b0;
      req = 4'b0;
      rel = 4'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset gnt", int'(d_gnt[0]), 0);
      chk("reset timeout", int'(d_to[0]), 0);
      RST_N = 1'b1;

      // Single requester, released by REL
      req = 4'b0100;
      tick();
      chk("t1 gnt", int'(d_gnt[0]), 4);
      chk("t1 id", int'(d_id[0]), 2);
      chk("t1 valid", int'(d_val[0]), 1);
      tick(); tick();
      rel = 4'b0100;
      tick();
      rel = 4'b0;
      chk("t1 gnt after rel", int'(d_gnt[0]), 0);
      req = 4'b0;
      repeat (3) tick();

      // Round-robin rotation with a two-cycle gap
      do_reset();
      req = 4'b1111;
      tick();
      for (int n = 0; n < 5; n++) begin
         chk($sformatf("t2 owner %0d", n), int'(d_id[0]), n % 4);
         chk($sformatf("t2 valid %0d", n), int'(d_val[0]), 1);
         tick(); tick();
         rel = d_gnt[0];
         tick();
         rel = 4'b0;
         if (n < 4) begin
            low = 1;
            for (int w = 0; w < 10; w++) begin
               tick();
               if (d_gnt[0] != 4'b0) break;
               low++;
            end
            chk($sformatf("t2 gap %0d", n), low, 2);
         end
      end
      req = 4'b0;

      // Fixed priority: no preemption, higher requester wins after release
      do_reset();
      req = 4'b0011;
      tick();
      chk("t3 fp first", int'(d_gnt[1]), 2);
      chk("t3 rr first", int'(d_gnt[0]), 1);
      req = 4'b1011;
      tick(); tick();
      chk("t3 no preempt", int'(d_gnt[1]), 2);
      rel = 4'b0010;
      tick();
      rel = 4'b0;
      chk("t3 released", int'(d_gnt[1]), 0);
      tick();
      chk("t3 next owner", int'(d_gnt[1]), 8);
      chk("t3 next id", int'(d_id[1]), 3);
      req = 4'b0;

      // Timeout and lockout
      do_reset();
      req = 4'b0010;
      tick();
      hi = 1;
      for (int w = 0; w < 20; w++) begin
         tick();
         if (d_gnt[0] == 4'b0) break;
         hi++;
      end
      chk("t4 hold cycles", hi, 8);
      chk("t4 pulse", int'(d_to[0]), 1);
      tick();
      chk("t4 pulse width", int'(d_to[0]), 0);
      repeat (4) tick();
      chk("t4 locked out", int'(d_gnt[0]), 0);
      req = 4'b0;
      tick();
      req = 4'b0010;
      tick();
      chk("t4 regrant", int'(d_gnt[0]), 2);

      // Owner drops REQ without REL
      do_reset();
      req = 4'b0100;
      tick();
      tick();
      req = 4'b0;
      tick();
      chk("t5a dropped", int'(d_gnt[0]), 0);
      chk("t5a no pulse", int'(d_to[0]), 0);

      // REL coincides with the last timer cycle: no pulse, no lockout
      do_reset();
      req = 4'b0100;
      tick();
      repeat (7) tick();
      rel = 4'b0100;
      tick();
      rel = 4'b0;
      chk("t5b dropped", int'(d_gnt[0]), 0);
      chk("t5b no pulse", int'(d_to[0]), 0);
      tick(); tick();
      chk("t5b not masked", int'(d_gnt[0]), 4);

      // Asynchronous reset mid-grant
      do_reset();
      req = 4'b1111;
      tick(); tick();
      #2;
      RST_N = 1'b0;
      #1;
      chk("t6 async gnt u0", int'(d_gnt[0]), 0);
      chk("t6 async gnt u1", int'(d_gnt[1]), 0);
      chk("t6 async valid", int'(d_val[0]), 0);
      chk("t6 async id", int'(d_id[0]), 0);
      chk("t6 async timeout", int'(d_to[0]), 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      tick();
      chk("t6 first after reset", int'(d_gnt[0]), 1);
      chk("t6 first id", int'(d_id[0]), 0);

      // Random traffic: slowly changing requests so timeouts and lockouts occur
      req = 4'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(15) == 0) req[b] = ~req[b];
         rel = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'b0;
         if (cyc == 2000) do_reset();
         else tick();
      end
      rel = 4'b0;
      req = 4'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
